// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential floating-point normalizer.
// The state and action enums are shared by the top and by debug tooling.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } stateT;

  // One datapath action per cycle, decided by the FSM.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_BYPASS,
    ACT_CARRY,
    ACT_ZERO,
    ACT_SHIFT,
    ACT_ROUND
  } normActionT;

endpackage

// File: rtl/fp_seq_normalizer_if.sv
// Operand/result handshake bundle between the aligner, the normalizer and its consumer.
// master = producer/consumer side, slave = normalizer side.
interface fp_seq_normalizer_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MANT_W:0]   alignedResult;
  logic              carryOut;
  logic              alignedSign;
  logic [EXP_W-1:0]  exponentOut;
  logic              guardBit;
  logic              roundBit;
  logic              stickyBit;

  logic              out_valid;
  logic              out_ready;
  logic              normalizedSign;
  logic [EXP_W-1:0]  normalizedExponent;
  logic [MANT_W-1:0] normalizedMantissa;
  logic              overflow;

  modport master (
    output in_valid, alignedResult, carryOut, alignedSign, exponentOut,
           guardBit, roundBit, stickyBit, out_ready,
    input  in_ready, out_valid, normalizedSign, normalizedExponent,
           normalizedMantissa, overflow
  );

  modport slave (
    input  in_valid, alignedResult, carryOut, alignedSign, exponentOut,
           guardBit, roundBit, stickyBit, out_ready,
    output in_ready, out_valid, normalizedSign, normalizedExponent,
           normalizedMantissa, overflow
  );

endinterface

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a 24-bit mantissa with guard/round/sticky.
// A mantissa wrap renormalises to 1.0 and bumps the exponent; reaching EXP_MAX flags overflow.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MANT_W:0]  mantRaw,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  input  logic [EXP_W-1:0] expRaw,
  output logic [MANT_W:0]  mantRounded,
  output logic [EXP_W-1:0] expRounded,
  output logic             overflow
);

  logic            roundUp;
  logic            wrap;
  logic [MANT_W+1:0] sum;

  always_comb begin
    roundUp     = g & (r | s | mantRaw[0]);
    sum         = {1'b0, mantRaw} + {{(MANT_W + 1){1'b0}}, roundUp};
    wrap        = sum[MANT_W+1];
    mantRounded = wrap ? {1'b1, {MANT_W{1'b0}}} : sum[MANT_W:0];
    expRounded  = expRaw + EXP_W'(wrap);
    // An exponent already at EXP_MAX (from a carry shift) overflows regardless of rounding.
    overflow    = (expRaw == EXP_MAX) || (expRounded == EXP_MAX);
  end

endmodule

// File: rtl/fp_seq_normalizer.sv
// Sequential post-ALU normalizer: one shift per cycle, then RNE rounding, result held
// under a valid/ready handshake until consumed.
module fp_seq_normalizer
  import fp_pkg::*;
(
  input logic                clk,
  input logic                reset,
  fp_seq_normalizer_if.slave bus
);

  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  stateT             state;
  stateT             nextState;
  normActionT        action;
  logic              accept;

  logic              carryReg;
  logic              guardReg;
  logic              roundReg;
  logic              stickyReg;
  logic              signReg;
  logic [MANT_W:0]   mantReg;
  logic [EXP_W-1:0]  expReg;

  logic              normSign;
  logic              overflowReg;
  logic [EXP_W-1:0]  normExp;
  logic [MANT_W-1:0] normMant;

  logic [MANT_W:0]   mantRounded;
  logic [EXP_W-1:0]  expRounded;
  logic              roundOverflow;

  assign accept = (state == IDLE) && bus.in_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    nextState = state;
    action    = ACT_NONE;
    unique case (state)
      IDLE: if (bus.in_valid) nextState = NORM;
      NORM: begin
        if (expReg == EXP_MAX) begin
          action    = ACT_BYPASS;
          nextState = DONE;
        end else if (carryReg) begin
          action    = ACT_CARRY;
          nextState = ROUND;
        end else if (mantReg == '0 && !(guardReg | roundReg | stickyReg)) begin
          action    = ACT_ZERO;
          nextState = DONE;
        end else if (!mantReg[MANT_W] && expReg > EXP_ONE) begin
          action    = ACT_SHIFT;
        end else begin
          nextState = ROUND;
        end
      end
      ROUND: begin
        action    = ACT_ROUND;
        nextState = DONE;
      end
      DONE: if (bus.out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: the working registers are cleared by the synchronous reset too, so an aborted operand leaves no residue.
  always_ff @(posedge clk) begin
    if (reset) begin
      carryReg  <= 1'b0;
      guardReg  <= 1'b0;
      roundReg  <= 1'b0;
      stickyReg <= 1'b0;
      signReg   <= 1'b0;
      mantReg   <= '0;
      expReg    <= '0;
    end else begin
      if (accept) begin
        carryReg  <= bus.carryOut;
        mantReg   <= bus.alignedResult;
        // A zero exponent field carries subnormal scale, i.e. the same weight as exponent 1.
        expReg    <= (bus.exponentOut == '0) ? EXP_ONE : bus.exponentOut;
        guardReg  <= bus.guardBit;
        roundReg  <= bus.roundBit;
        stickyReg <= bus.stickyBit;
        signReg   <= bus.alignedSign;
      end
      case (action)
        ACT_CARRY: begin
          mantReg   <= {1'b1, mantReg[MANT_W:1]};
          guardReg  <= mantReg[0];
          roundReg  <= guardReg;
          stickyReg <= stickyReg | roundReg;
          expReg    <= expReg + EXP_ONE;
          carryReg  <= 1'b0;
        end
        ACT_SHIFT: begin
          mantReg  <= {mantReg[MANT_W-1:0], guardReg};
          guardReg <= roundReg;
          roundReg <= 1'b0;
          expReg   <= expReg - EXP_ONE;
        end
        default: ;
      endcase
    end
  end

  fp_round_rne roundUnit (
    .mantRaw     (mantReg),
    .g           (guardReg),
    .r           (roundReg),
    .s           (stickyReg),
    .expRaw      (expReg),
    .mantRounded (mantRounded),
    .expRounded  (expRounded),
    .overflow    (roundOverflow)
  );

  // Result registers change only when DONE is entered; overflow alone clears on accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      normSign    <= 1'b0;
      normExp     <= '0;
      normMant    <= '0;
      overflowReg <= 1'b0;
    end else begin
      if (accept) overflowReg <= 1'b0;
      case (action)
        ACT_BYPASS: begin
          normSign <= signReg;
          normExp  <= EXP_MAX;
          normMant <= mantReg[MANT_W-1:0];
        end
        ACT_ZERO: begin
          normSign <= 1'b0;
          normExp  <= '0;
          normMant <= '0;
        end
        ACT_ROUND: begin
          normSign <= signReg;
          if (roundOverflow) begin
            normExp     <= EXP_MAX;
            normMant    <= '0;
            overflowReg <= 1'b1;
          end else begin
            // Without the hidden bit the result is subnormal and encodes exponent 0.
            normExp  <= mantRounded[MANT_W] ? expRounded : '0;
            normMant <= mantRounded[MANT_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready           = (state == IDLE);
  assign bus.out_valid          = (state == DONE);
  assign bus.normalizedSign     = normSign;
  assign bus.normalizedExponent = normExp;
  assign bus.normalizedMantissa = normMant;
  assign bus.overflow           = overflowReg;

endmodule

// File: tb/tb_fp_seq_normalizer.sv
// Directed bench for fp_seq_normalizer: hand-computed results and latencies per scenario.
// Result vectors are packed as {overflow, sign, exponent, mantissa}.
module tb_fp_seq_normalizer;
  import fp_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_seq_normalizer_if bus ();

  fp_seq_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [32:0] observed();
    return {bus.overflow, bus.normalizedSign, bus.normalizedExponent, bus.normalizedMantissa};
  endfunction

  // Present one operand while IDLE; returns #1 after the accept edge.
  task automatic offer(input logic [23:0] m, input logic c, input logic sg,
                       input logic [7:0] e, input logic [2:0] grs);
    bus.alignedResult = m;
    bus.carryOut      = c;
    bus.alignedSign   = sg;
    bus.exponentOut   = e;
    {bus.guardBit, bus.roundBit, bus.stickyBit} = grs;
    bus.in_valid      = 1'b1;
    @(posedge clk); #1;
    bus.in_valid      = 1'b0;
  endtask

  // Count edges from accept until out_valid, bounded at 40.
  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [23:0] m, input logic c, input logic sg, input logic [7:0] e,
                        input logic [2:0] grs, output int lat, output logic [32:0] res);
    offer(m, c, sg, e, grs);
    wait_out(lat);
    res = observed();
    handshake();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_handshake: got %b expected 10", {bus.in_ready, bus.out_valid});
    end
    checks++;
    if (observed() !== 33'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", observed());
    end
  endtask

  task automatic test_normalized();
    int lat; logic [32:0] res;
    run_op(24'hC00000, 1'b0, 1'b0, 8'h7F, 3'b000, lat, res);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL norm_latency: got %0d expected 2", lat); end
    checks++;
    if (res !== {1'b0, 1'b0, 8'h7F, 23'h400000}) begin
      errors++; $display("FAIL norm_result: got %h expected %h", res, {1'b0, 1'b0, 8'h7F, 23'h400000});
    end
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++; $display("FAIL norm_release: got %b expected 10", {bus.in_ready, bus.out_valid});
    end
    run_op(24'hA00000, 1'b0, 1'b1, 8'h10, 3'b000, lat, res);
    checks++;
    if (res !== {1'b0, 1'b1, 8'h10, 23'h200000}) begin
      errors++; $display("FAIL norm_negative: got %h expected %h", res, {1'b0, 1'b1, 8'h10, 23'h200000});
    end
    // One left shift pulls the guard bit into the LSB; latency grows by one.
    run_op(24'h400000, 1'b0, 1'b0, 8'h7F, 3'b100, lat, res);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL shift1_latency: got %0d expected 3", lat); end
    checks++;
    if (res !== {1'b0, 1'b0, 8'h7E, 23'h000001}) begin
      errors++; $display("FAIL shift1_result: got %h expected %h", res, {1'b0, 1'b0, 8'h7E, 23'h000001});
    end
  endtask

  task automatic test_carry();
    int lat; logic [32:0] res;
    run_op(24'h800000, 1'b1, 1'b0, 8'h7F, 3'b000, lat, res);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL carry_latency: got %0d expected 2", lat); end
    checks++;
    if (res !== {1'b0, 1'b0, 8'h80, 23'h400000}) begin
      errors++; $display("FAIL carry_result: got %h expected %h", res, {1'b0, 1'b0, 8'h80, 23'h400000});
    end
    // Shifted-out LSB becomes guard with mant[0]=1 after the shift, so it rounds up.
    run_op(24'h800003, 1'b1, 1'b0, 8'h7F, 3'b000, lat, res);
    checks++;
    if (res !== {1'b0, 1'b0, 8'h80, 23'h400002}) begin
      errors++; $display("FAIL carry_round: got %h expected %h", res, {1'b0, 1'b0, 8'h80, 23'h400002});
    end
    run_op(24'h800000, 1'b1, 1'b0, 8'hFE, 3'b000, lat, res);
    checks++;
    if (res !== {1'b1, 1'b0, 8'hFF, 23'h000000}) begin
      errors++; $display("FAIL carry_overflow: got %h expected %h", res, {1'b1, 1'b0, 8'hFF, 23'h000000});
    end
    // Overflow drops at the next accept; the other outputs hold until DONE.
    offer(24'hC00000, 1'b0, 1'b0, 8'h7F, 3'b000);
    checks++;
    if (observed() !== {1'b0, 1'b0, 8'hFF, 23'h000000}) begin
      errors++; $display("FAIL overflow_clear: got %h expected %h", observed(), {1'b0, 1'b0, 8'hFF, 23'h000000});
    end
    wait_out(lat);
    res = observed();
    handshake();
    checks++;
    if (res !== {1'b0, 1'b0, 8'h7F, 23'h400000}) begin
      errors++; $display("FAIL after_overflow: got %h expected %h", res, {1'b0, 1'b0, 8'h7F, 23'h400000});
    end
  endtask

  task automatic test_round();
    int lat; logic [32:0] res;
    run_op(24'hFFFFFF, 1'b0, 1'b0, 8'h7F, 3'b100, lat, res);
    checks++;
    if (res !== {1'b0, 1'b0, 8'h80, 23'h000000}) begin
      errors++; $display("FAIL round_wrap: got %h expected %h", res, {1'b0, 1'b0, 8'h80, 23'h000000});
    end
    run_op(24'h800000, 1'b0, 1'b0, 8'h7F, 3'b100, lat, res);
    checks++;
    if (res !== {1'b0, 1'b0, 8'h7F, 23'h000000}) begin
      errors++; $display("FAIL round_tie_even: got %h expected %h", res, {1'b0, 1'b0, 8'h7F, 23'h000000});
    end
    run_op(24'h800001, 1'b0, 1'b0, 8'h7F, 3'b100, lat, res);
    checks++;
    if (res !== {1'b0, 1'b0, 8'h7F, 23'h000002}) begin
      errors++; $display("FAIL round_tie_odd: got %h expected %h", res, {1'b0, 1'b0, 8'h7F, 23'h000002});
    end
    run_op(24'hFFFFFF, 1'b0, 1'b0, 8'hFE, 3'b100, lat, res);
    checks++;
    if (res !== {1'b1, 1'b0, 8'hFF, 23'h000000}) begin
      errors++; $display("FAIL round_overflow: got %h expected %h", res, {1'b1, 1'b0, 8'hFF, 23'h000000});
    end
  endtask

  task automatic test_subnormal();
    int lat; logic [32:0] res;
    run_op(24'h000010, 1'b0, 1'b0, 8'h00, 3'b000, lat, res);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL subnorm_latency: got %0d expected 2", lat); end
    checks++;
    if (res !== {1'b0, 1'b0, 8'h00, 23'h000010}) begin
      errors++; $display("FAIL subnorm_result: got %h expected %h", res, {1'b0, 1'b0, 8'h00, 23'h000010});
    end
    run_op(24'h7FFFFF, 1'b0, 1'b0, 8'h00, 3'b110, lat, res);
    checks++;
    if (res !== {1'b0, 1'b0, 8'h01, 23'h000000}) begin
      errors++; $display("FAIL subnorm_round_up: got %h expected %h", res, {1'b0, 1'b0, 8'h01, 23'h000000});
    end
    // Shifting stops once the exponent reaches 1.
    run_op(24'h000001, 1'b0, 1'b0, 8'h03, 3'b000, lat, res);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL subnorm_shift_latency: got %0d expected 4", lat); end
    checks++;
    if (res !== {1'b0, 1'b0, 8'h00, 23'h000004}) begin
      errors++; $display("FAIL subnorm_shift_result: got %h expected %h", res, {1'b0, 1'b0, 8'h00, 23'h000004});
    end
  endtask

  task automatic test_bypass();
    int lat; logic [32:0] res;
    run_op(24'h123456, 1'b0, 1'b1, 8'hFF, 3'b111, lat, res);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL bypass_latency: got %0d expected 1", lat); end
    checks++;
    if (res !== {1'b0, 1'b1, 8'hFF, 23'h123456}) begin
      errors++; $display("FAIL bypass_result: got %h expected %h", res, {1'b0, 1'b1, 8'hFF, 23'h123456});
    end
    run_op(24'hC00001, 1'b1, 1'b0, 8'hFF, 3'b000, lat, res);
    checks++;
    if (res !== {1'b0, 1'b0, 8'hFF, 23'h400001}) begin
      errors++; $display("FAIL bypass_carry: got %h expected %h", res, {1'b0, 1'b0, 8'hFF, 23'h400001});
    end
  endtask

  task automatic test_zero_backpressure();
    int lat;
    offer(24'h000000, 1'b0, 1'b1, 8'h40, 3'b000);
    wait_out(lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    for (int i = 0; i < 5; i++) begin
      // Competing operand while busy must be ignored.
      bus.alignedResult = 24'hC00000;
      bus.exponentOut   = 8'h55;
      bus.in_valid      = 1'b1;
      checks++;
      if ({bus.out_valid, bus.in_ready, observed()} !== {1'b1, 1'b0, 33'h0}) begin
        errors++; $display("FAIL backpressure_hold[%0d]: got %h expected %h", i,
                           {bus.out_valid, bus.in_ready, observed()}, {1'b1, 1'b0, 33'h0});
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, observed()} !== {1'b1, 1'b0, 33'h0}) begin
      errors++; $display("FAIL backpressure_release: got %h expected %h",
                         {bus.in_ready, bus.out_valid, observed()}, {1'b1, 1'b0, 33'h0});
    end
  endtask

  task automatic test_deep_shift();
    int lat; logic [32:0] res;
    run_op(24'h000001, 1'b0, 1'b0, 8'h7F, 3'b000, lat, res);
    checks++;
    if (lat !== 25) begin errors++; $display("FAIL deep_latency: got %0d expected 25", lat); end
    checks++;
    if (res !== {1'b0, 1'b0, 8'h68, 23'h000000}) begin
      errors++; $display("FAIL deep_result: got %h expected %h", res, {1'b0, 1'b0, 8'h68, 23'h000000});
    end
    // Abort the same operand mid-shift.
    offer(24'h000001, 1'b0, 1'b0, 8'h7F, 3'b000);
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++; $display("FAIL midnorm_reset_handshake: got %b expected 01", {bus.out_valid, bus.in_ready});
    end
    checks++;
    if (observed() !== 33'h0) begin
      errors++; $display("FAIL midnorm_reset_outputs: got %h expected 0", observed());
    end
    run_op(24'hC00000, 1'b0, 1'b0, 8'h7F, 3'b000, lat, res);
    checks++;
    if (lat !== 2 || res !== {1'b0, 1'b0, 8'h7F, 23'h400000}) begin
      errors++; $display("FAIL post_reset_op: got lat %0d res %h expected lat 2 res %h", lat, res,
                         {1'b0, 1'b0, 8'h7F, 23'h400000});
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.alignedResult = '0;
    bus.carryOut      = 1'b0;
    bus.alignedSign   = 1'b0;
    bus.exponentOut   = '0;
    bus.guardBit      = 1'b0;
    bus.roundBit      = 1'b0;
    bus.stickyBit     = 1'b0;

    test_reset();
    test_normalized();
    test_carry();
    test_round();
    test_subnormal();
    test_bypass();
    test_zero_backpressure();
    test_deep_shift();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
